rename_multi: RTL

- Parametrised multi-wide register-rename stage; successor of the single-issue renamer.
- Renames up to RENAME_WIDTH instructions per cycle against a speculative RAT holding tag, value and ready bit.
- Resolves intra-group dependencies, accepts NUM_WAKEUP FU broadcasts and NUM_FREE ROB tag returns per cycle.
- Back-pressures decode with a valid/ready handshake instead of aborting on an empty free pool. Sits between decode and reservation station / ROB allocation.

---
 rtl/rename_multi.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rename_multi.sv
// Multi-wide register rename stage: speculative RAT (tag/value/ready) with
// intra-group dependency bypass, wakeup forwarding and a circular free-tag FIFO.

module rename_multi_chk #(
   parameter int NUM_ARCH_REGS = 32,
   parameter int NUM_PHYS_REGS = 64,
   parameter int NUM_WAKEUP    = 2,
   parameter int NUM_FREE      = 2,
   localparam int TW = $clog2(NUM_PHYS_REGS),
   localparam int POOL_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS,
   localparam int CW = $clog2(POOL_DEPTH + 1),
   localparam int PW = (POOL_DEPTH > 1) ? $clog2(POOL_DEPTH) : 1,
   localparam int NW = CW + 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NW-1:0]            count_next,
   input  logic [NUM_WAKEUP-1:0]    wakeup_valid,
   input  logic [NUM_WAKEUP*TW-1:0] wakeup_tag,
   input  logic [NUM_FREE*TW-1:0]   freed_tag,
   input  logic [TW-1:0]            rat_tag [NUM_ARCH_REGS],
   input  logic                     rat_ready [NUM_ARCH_REGS],
   input  logic [TW-1:0]            pool [POOL_DEPTH],
   input  logic [PW-1:0]            head,
   input  logic [CW-1:0]            free_count
);
   // Stop simulation on producer behaviour the rename stage cannot tolerate
   always @(posedge clk) begin
      if (reset) begin
         if (count_next > NW'(POOL_DEPTH))
            $fatal(1, "rename_multi: free pool overflow");
         for (int a = 0; a < NUM_WAKEUP; a++) begin
            for (int b = a + 1; b < NUM_WAKEUP; b++) begin
               if (wakeup_valid[a] && wakeup_valid[b] &&
                   wakeup_tag[a*TW +: TW] == wakeup_tag[b*TW +: TW])
                  $fatal(1, "rename_multi: duplicate wakeup tag");
            end
            for (int i = 1; i < NUM_ARCH_REGS; i++) begin
               if (wakeup_valid[a] && rat_ready[i] && rat_tag[i] == wakeup_tag[a*TW +: TW])
                  $fatal(1, "rename_multi: wakeup of an already ready entry");
            end
         end
         for (int p = 0; p < NUM_FREE; p++) begin
            if (freed_tag[p*TW +: TW] != '0) begin
               for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                  if (rat_tag[i] == freed_tag[p*TW +: TW])
                     $fatal(1, "rename_multi: freed tag still mapped");
               end
               for (int q = 0; q < POOL_DEPTH; q++) begin
                  if (((q + POOL_DEPTH - int'(head)) % POOL_DEPTH) < int'(free_count) &&
                      pool[q] == freed_tag[p*TW +: TW])
                     $fatal(1, "rename_multi: freed tag already in pool");
               end
            end
         end
      end
   end
endmodule

module rename_multi #(
   parameter int RENAME_WIDTH  = 2,
   parameter int NUM_ARCH_REGS = 32,
   parameter int NUM_PHYS_REGS = 64,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_WAKEUP    = 2,
   parameter int NUM_FREE      = 2,
   localparam int AW = $clog2(NUM_ARCH_REGS),
   localparam int TW = $clog2(NUM_PHYS_REGS),
   localparam int POOL_DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS,
   localparam int CW = $clog2(POOL_DEPTH + 1)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [RENAME_WIDTH*AW-1:0]       arch_rd,
   input  logic [RENAME_WIDTH*AW-1:0]       arch_rs1,
   input  logic [RENAME_WIDTH*AW-1:0]       arch_rs2,
   output logic [RENAME_WIDTH*TW-1:0]       phys_rd,
   output logic [RENAME_WIDTH*TW-1:0]       phys_rs1,
   output logic [RENAME_WIDTH*TW-1:0]       phys_rs2,
   output logic [RENAME_WIDTH-1:0]          rs1_ready,
   output logic [RENAME_WIDTH-1:0]          rs2_ready,
   output logic [RENAME_WIDTH*DATA_WIDTH-1:0] rs1_value,
   output logic [RENAME_WIDTH*DATA_WIDTH-1:0] rs2_value,
   input  logic [NUM_WAKEUP-1:0]            wakeup_valid,
   input  logic [NUM_WAKEUP*TW-1:0]         wakeup_tag,
   input  logic [NUM_WAKEUP*DATA_WIDTH-1:0] wakeup_value,
   input  logic [NUM_FREE*TW-1:0]           freed_tag,
   output logic [CW-1:0]                    free_count
);
   localparam int PW = (POOL_DEPTH > 1) ? $clog2(POOL_DEPTH) : 1;
   localparam int SW = PW + CW + 1;
   localparam int NW = CW + 2;

   logic [TW-1:0]         rat_tag   [NUM_ARCH_REGS];
   logic [DATA_WIDTH-1:0] rat_value [NUM_ARCH_REGS];
   logic                  rat_ready [NUM_ARCH_REGS];
   logic [TW-1:0]         pool      [POOL_DEPTH];
   logic [PW-1:0]         head;
   logic [PW-1:0]         tail;

   logic [CW-1:0]         alloc_off [RENAME_WIDTH];
   logic [CW-1:0]         nalloc;
   logic [TW-1:0]         rd_tag    [RENAME_WIDTH];
   logic [CW-1:0]         free_off  [NUM_FREE];
   logic [CW-1:0]         nfree;
   logic                  fire;
   logic [NW-1:0]         count_next;

   logic [TW-1:0]         src_tag [2][RENAME_WIDTH];
   logic                  src_rdy [2][RENAME_WIDTH];
   logic [DATA_WIDTH-1:0] src_val [2][RENAME_WIDTH];

   function automatic logic [PW-1:0] wrap_ptr(input logic [PW-1:0] base, input logic [CW-1:0] off);
      logic [SW-1:0] sum;
      sum = {{(CW+1){1'b0}}, base} + {{(PW+1){1'b0}}, off};
      return PW'(sum % SW'(POOL_DEPTH));
   endfunction

   // Slot allocation offsets: each renaming slot takes the tag after older renaming slots
   always_comb begin
      nalloc = '0;
      for (int k = 0; k < RENAME_WIDTH; k++) begin
         alloc_off[k] = nalloc;
         if (arch_rd[k*AW +: AW] != '0) begin
            nalloc = nalloc + CW'(1);
         end else begin
            nalloc = nalloc;
         end
      end
   end

   // Destination tags straight from the pool head window
   always_comb begin
      for (int k = 0; k < RENAME_WIDTH; k++) begin
         if (arch_rd[k*AW +: AW] != '0) begin
            rd_tag[k] = pool[wrap_ptr(head, alloc_off[k])];
         end else begin
            rd_tag[k] = '0;
         end
      end
   end

   // Freed-tag offsets: nonzero ports pack into the tail in port order
   always_comb begin
      nfree = '0;
      for (int p = 0; p < NUM_FREE; p++) begin
         free_off[p] = nfree;
         if (freed_tag[p*TW +: TW] != '0) begin
            nfree = nfree + CW'(1);
         end else begin
            nfree = nfree;
         end
      end
   end

   // Handshake and next occupancy; frees this cycle do not help acceptance
   always_comb begin
      in_ready   = (free_count >= nalloc);
      fire       = in_valid && in_ready;
      count_next = {2'b00, free_count} + NW'(nfree) - (fire ? NW'(nalloc) : NW'(0));
   end

   // Operand lookup: RAT with wakeup bypass, then older same-group writers, then x0
   always_comb begin
      logic [AW-1:0] a;
      a = '0;
      for (int o = 0; o < 2; o++) begin
         for (int k = 0; k < RENAME_WIDTH; k++) begin
            a = (o == 0) ? arch_rs1[k*AW +: AW] : arch_rs2[k*AW +: AW];
            src_tag[o][k] = rat_tag[a];
            src_rdy[o][k] = rat_ready[a];
            src_val[o][k] = rat_value[a];
            for (int w = 0; w < NUM_WAKEUP; w++) begin
               if (wakeup_valid[w] && wakeup_tag[w*TW +: TW] == rat_tag[a]) begin
                  src_rdy[o][k] = 1'b1;
                  src_val[o][k] = wakeup_value[w*DATA_WIDTH +: DATA_WIDTH];
               end else begin
                  src_rdy[o][k] = src_rdy[o][k];
               end
            end
            for (int j = 0; j < k; j++) begin
               if (arch_rd[j*AW +: AW] == a) begin
                  src_tag[o][k] = rd_tag[j];
                  src_rdy[o][k] = 1'b0;
               end else begin
                  src_rdy[o][k] = src_rdy[o][k];
               end
            end
            if (a == '0) begin
               src_tag[o][k] = '0;
               src_rdy[o][k] = 1'b1;
               src_val[o][k] = '0;
            end else if (!src_rdy[o][k]) begin
               src_val[o][k] = {DATA_WIDTH{1'b1}};
            end else begin
               src_val[o][k] = src_val[o][k];
            end
         end
      end
   end

   // Pack per-slot results onto the flat output buses
   always_comb begin
      phys_rd   = '0;
      phys_rs1  = '0;
      phys_rs2  = '0;
      rs1_ready = '0;
      rs2_ready = '0;
      rs1_value = '0;
      rs2_value = '0;
      for (int k = 0; k < RENAME_WIDTH; k++) begin
         phys_rd[k*TW +: TW]                = rd_tag[k];
         phys_rs1[k*TW +: TW]               = src_tag[0][k];
         phys_rs2[k*TW +: TW]               = src_tag[1][k];
         rs1_ready[k]                       = src_rdy[0][k];
         rs2_ready[k]                       = src_rdy[1][k];
         rs1_value[k*DATA_WIDTH +: DATA_WIDTH] = src_val[0][k];
         rs2_value[k*DATA_WIDTH +: DATA_WIDTH] = src_val[1][k];
      end
   end

   // RAT update: wakeups mark entries ready, a same-cycle rename (youngest slot) overrides
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            rat_tag[i]   <= TW'(i);
            rat_value[i] <= '0;
            rat_ready[i] <= 1'b1;
         end
      end else begin
         for (int i = 1; i < NUM_ARCH_REGS; i++) begin
            for (int w = 0; w < NUM_WAKEUP; w++) begin
               if (wakeup_valid[w] && wakeup_tag[w*TW +: TW] == rat_tag[i]) begin
                  rat_ready[i] <= 1'b1;
                  rat_value[i] <= wakeup_value[w*DATA_WIDTH +: DATA_WIDTH];
               end
            end
            for (int k = 0; k < RENAME_WIDTH; k++) begin
               if (fire && arch_rd[k*AW +: AW] == AW'(i)) begin
                  rat_tag[i]   <= rd_tag[k];
                  rat_ready[i] <= 1'b0;
                  rat_value[i] <= {DATA_WIDTH{1'b1}};
               end
            end
         end
      end
   end

   // Free pool FIFO: pops at head on fire, pushes returned tags at tail
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < POOL_DEPTH; i++) begin
            pool[i] <= TW'(NUM_ARCH_REGS + i);
         end
         head       <= '0;
         tail       <= '0;
         free_count <= CW'(POOL_DEPTH);
      end else begin
         for (int p = 0; p < NUM_FREE; p++) begin
            if (freed_tag[p*TW +: TW] != '0) begin
               pool[wrap_ptr(tail, free_off[p])] <= freed_tag[p*TW +: TW];
            end
         end
         tail <= wrap_ptr(tail, nfree);
         if (fire) begin
            head <= wrap_ptr(head, nalloc);
         end
         free_count <= CW'(count_next);
      end
   end

`ifndef SYNTHESIS
   rename_multi_chk #(
      .NUM_ARCH_REGS (NUM_ARCH_REGS),
      .NUM_PHYS_REGS (NUM_PHYS_REGS),
      .NUM_WAKEUP    (NUM_WAKEUP),
      .NUM_FREE      (NUM_FREE)
   ) u_chk (
      .clk          (clk),
      .reset        (reset),
      .count_next   (count_next),
      .wakeup_valid (wakeup_valid),
      .wakeup_tag   (wakeup_tag),
      .freed_tag    (freed_tag),
      .rat_tag      (rat_tag),
      .rat_ready    (rat_ready),
      .pool         (pool),
      .head         (head),
      .free_count   (free_count)
   );
`endif
endmodule
